// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } add_state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder: two half-adder stages plus an OR of their carries.
module fa_bit_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1 = x ^ y;
    assign hc1 = x & y;
    assign s   = hs1 ^ z;
    assign hc2 = hs1 & z;
    assign c   = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    add_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;

    fa_bit_cell u_cell (
        .x(a_sr[0]),
        .y(b_sr[0]),
        .z(carry),
        .s(cell_s),
        .c(cell_c)
    );

    // Sum bits enter at the MSB and shift down, so after WIDTH steps bit 0 is the first cell result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= 1'b0;
`endif
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= cell_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        cout  <= cell_c;
                        done  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= (a_sr[0] == b_sr[0]) && (cell_s != a_sr[0]);
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 2 and 16 against an arithmetic reference.
// Also checks the ovf output when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2, ovf2;
    logic [1:0] a2 = '0, b2 = '0, sum2;
    logic        start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16, ovf16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf8),
`endif
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf2),
`endif
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf16),
`endif
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf2 = 1'b0;
    assign ovf16 = 1'b0;
`endif

    // Runs one WIDTH=8 operation from IDLE; operands are scrambled right after the accept edge.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output int lat, output logic busy_first, output logic [7:0] s,
                           output logic co, output logic ov, output logic done_after,
                           output logic busy_after);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        busy_first = busy8;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = sum8; co = cout8; ov = ovf8;
        @(negedge clk);
        done_after = done8;
        busy_after = busy8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
            failures++;
            $display("[TB] FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        checks++;
        if ({busy2, done2, sum2, cout2, busy16, done16, sum16, cout16} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_w2_w16 got busy2=%b sum2=%h busy16=%b sum16=%h want 0",
                     busy2, sum2, busy16, sum16);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic c);
        int lat;
        logic bf, co, ov, da, ba;
        logic [7:0] s;
        logic [8:0] exp;
        logic exp_ovf;
        exp = 9'(a) + 9'(b) + 9'(c);
        exp_ovf = (a[7] == b[7]) && (exp[7] != a[7]);
        run_op8(a, b, c, lat, bf, s, co, ov, da, ba);
        checks++;
        if (bf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s busy_after_start got %b want 1", name, bf);
        end
        checks++;
        if (lat != 9) begin
            failures++;
            $display("[TB] FAIL %s latency got %0d want 9", name, lat);
        end
        checks++;
        if ({co, s} !== exp) begin
            failures++;
            $display("[TB] FAIL %s result got cout=%b sum=%h want cout=%b sum=%h",
                     name, co, s, exp[8], exp[7:0]);
        end
        checks++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s done_width got done=%b busy=%b next cycle want 0 0",
                     name, da, ba);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ov !== exp_ovf) begin
            failures++;
            $display("[TB] FAIL %s ovf got %b want %b", name, ov, exp_ovf);
        end
`endif
    endtask

    task automatic test_directed();
        check_op8("add_0f_01", 8'h0F, 8'h01, 1'b0);
        check_op8("add_ff_01", 8'hFF, 8'h01, 1'b0);
        check_op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        check_op8("add_7f_01", 8'h7F, 8'h01, 1'b0);
        check_op8("add_80_ff", 8'h80, 8'hFF, 1'b0);
        check_op8("add_10_20", 8'h10, 8'h20, 1'b0);
        check_op8("add_00_00", 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_random_w8();
        for (int i = 0; i < 200; i++)
            check_op8("rand8", 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // start held high: second op must begin only after DONE, spaced WIDTH+2 cycles apart.
    task automatic test_back_to_back();
        int done_cyc[$];
        logic [7:0] sums[$];
        logic [8:0] exp1, exp2;
        exp1 = 9'(8'h3C) + 9'(8'h21) + 9'd1;
        exp2 = 9'(8'h55) + 9'(8'h21) + 9'd1;
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h21; cin8 = 1'b1; start8 = 1'b1;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (cyc == 3) a8 = 8'h55;
            if (done8) begin
                done_cyc.push_back(cyc);
                sums.push_back(sum8);
            end
            if (cyc == 19) start8 = 1'b0;
        end
        checks++;
        if (done_cyc.size() != 2) begin
            failures++;
            $display("[TB] FAIL b2b_done_count got %0d want 2", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != 9 || done_cyc[1] != 19) begin
                failures++;
                $display("[TB] FAIL b2b_done_cycles got %0d,%0d want 9,19",
                         done_cyc[0], done_cyc[1]);
            end
            checks++;
            if (sums[0] !== exp1[7:0] || sums[1] !== exp2[7:0]) begin
                failures++;
                $display("[TB] FAIL b2b_sums got %h,%h want %h,%h",
                         sums[0], sums[1], exp1[7:0], exp2[7:0]);
            end
        end
        checks++;
        if (busy8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle got busy=%b want 0", busy8);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int stray;
        logic bf, co, ov, da, ba;
        logic [7:0] s;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy8, done8, sum8, cout8);
        end
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_abort got %0d active cycles want 0", stray);
        end
        check_op8("after_reset", 8'hA5, 8'h5A, 1'b1);
    endtask

    task automatic test_random_w2();
        int lat, bad_width;
        logic [2:0] exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom); start2 = 1'b1;
            exp = 3'(a2) + 3'(b2) + 3'(cin2);
            @(negedge clk);
            start2 = 1'b0;
            a2 = 2'($urandom); b2 = 2'($urandom);
            lat = 1;
            while (!done2 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (!done2 || {cout2, sum2} !== exp) begin
                failures++;
                $display("[TB] FAIL rand2 op %0d got done=%b cout=%b sum=%h want cout=%b sum=%h",
                         i, done2, cout2, sum2, exp[2], exp[1:0]);
            end
            @(negedge clk);
            bad_width = done2 ? 1 : 0;
            checks++;
            if (bad_width != 0 || lat != 3) begin
                failures++;
                $display("[TB] FAIL rand2_timing op %0d got lat=%0d done_next=%0d want 3 0",
                         i, lat, bad_width);
            end
        end
    endtask

    task automatic test_random_w16();
        int lat, bad_width;
        logic [16:0] exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); start16 = 1'b1;
            exp = 17'(a16) + 17'(b16) + 17'(cin16);
            @(negedge clk);
            start16 = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom);
            lat = 1;
            while (!done16 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (!done16 || {cout16, sum16} !== exp) begin
                failures++;
                $display("[TB] FAIL rand16 op %0d got done=%b cout=%b sum=%h want cout=%b sum=%h",
                         i, done16, cout16, sum16, exp[16], exp[15:0]);
            end
            @(negedge clk);
            bad_width = done16 ? 1 : 0;
            checks++;
            if (bad_width != 0 || lat != 17) begin
                failures++;
                $display("[TB] FAIL rand16_timing op %0d got lat=%0d done_next=%0d want 17 0",
                         i, lat, bad_width);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random_w8();
        test_random_w2();
        test_random_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
